// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event receiver.
// Frame states, scan-code prefixes, the event word and the frame validity check.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  // Odd parity over data+parity, and a high stop bit.
  function automatic logic frame_ok(input logic [7:0] code, input logic par, input logic stop);
    return ((^code) ^ par) & stop;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO with occupancy level; accepts push-while-full when a pop
// happens in the same cycle.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     push_ok,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign push_ok = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: synchronises the bus, validates frames, folds E0/F0
// prefixes into key events and queues them behind a valid/ready handshake.
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int COUNT_W        = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          evt_ready,
  input  logic                          ovf_clr,
  output logic                          evt_valid,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          busy,
  output logic [COUNT_W-1:0]            key_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic            sclk_p0, sclk_p1, sclk_p2;
  logic            sdat_p0, sdat_p1;
  logic            fall;
  frame_state_t    state, state_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [TO_W-1:0] to_cnt;
  logic            timed_out;
  logic [7:0]      shift;
  logic            par;
  logic            good_n, err_n, good_p1;
  logic            ext_f, brk_f, ext_n, brk_n;
  logic            push_req, push_ok, full, empty, drop;
  key_evt_t        evt_in, head;
  logic [9:0]      head_raw;

  // Stage boundary: two-flop synchronisers plus one delayed clock for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_p0 <= 1'b1; sclk_p1 <= 1'b1; sclk_p2 <= 1'b1;
      sdat_p0 <= 1'b1; sdat_p1 <= 1'b1;
    end else begin
      sclk_p0 <= ps2_clk;  sclk_p1 <= sclk_p0; sclk_p2 <= sclk_p1;
      sdat_p0 <= ps2_data; sdat_p1 <= sdat_p0;
    end
  end

  assign fall      = sclk_p2 & ~sclk_p1;
  assign timed_out = (to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    good_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE:   if (fall && !sdat_p1) begin
                state_n   = DATA;
                bit_cnt_n = '0;
              end
      DATA:   if (fall) begin
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_n = PARITY;
              end
      PARITY: if (fall) state_n = STOP;
      STOP:   if (fall) begin
                state_n = IDLE;
                if (frame_ok(shift, par, sdat_p1)) good_n = 1'b1;
                else                               err_n  = 1'b1;
              end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && !fall && timed_out) begin
      state_n = IDLE;
      good_n  = 1'b0;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      good_p1   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      good_p1   <= good_n;
      frame_err <= err_n;
      if (fall)            to_cnt <= '0;
      else if (!timed_out) to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fall && state == DATA)   shift <= {sdat_p1, shift[7:1]};
    if (fall && state == PARITY) par   <= sdat_p1;
  end

  // Stage boundary: good byte in shift is decoded one cycle after the stop bit.
  always_comb begin
    push_req = 1'b0;
    ext_n    = ext_f;
    brk_n    = brk_f;
    evt_in   = '{ext: ext_f, brk: brk_f, code: shift};
    if (good_p1) begin
      if (shift == PFX_EXT)      ext_n = 1'b1;
      else if (shift == PFX_BRK) brk_n = 1'b1;
      else begin
        push_req = 1'b1;
        ext_n    = 1'b0;
        brk_n    = 1'b0;
      end
    end
  end

  assign drop = push_req & full & ~(evt_valid & evt_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      overflow  <= 1'b0;
      key_count <= '0;
    end else begin
      ext_f <= ext_n;
      brk_f <= brk_n;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (push_ok && !evt_in.brk) key_count <= key_count + COUNT_W'(1);
    end
  end

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(10)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_req),
    .wdata   (evt_in),
    .pop     (evt_ready),
    .rdata   (head_raw),
    .push_ok (push_ok),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign head      = key_evt_t'(head_raw);
  assign evt_valid = ~empty;
  assign evt_code  = evt_valid ? head.code : 8'h00;
  assign evt_ext   = evt_valid & head.ext;
  assign evt_break = evt_valid & head.brk;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Scoreboard bench for ps2_key_event_rx: expected events are queued as frames are
// driven and compared as the DUT hands them off.
module tb_ps2_key_event_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int HALF  = 8;

  logic       clk = 0;
  logic       rst = 0;
  logic       ps2_clk = 1, ps2_data = 1;
  logic       evt_ready = 0, ovf_clr = 0;
  logic       evt_valid, evt_ext, evt_break, overflow, frame_err, busy;
  logic [7:0] evt_code, key_count;
  logic [3:0] fifo_level;

  ps2_key_event_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(evt_valid),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
    .overflow(overflow), .frame_err(frame_err), .busy(busy),
    .key_count(key_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [9:0] sbq[$];
  int err_cycles = 0, vcycles = 0, popped = 0, peak = 0;
  int mark = 0, last_mark = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (mark != last_mark) begin peak = 0; last_mark = mark; end
      if (frame_err) err_cycles++;
      if (evt_valid) vcycles++;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (evt_valid && evt_ready) begin
        popped++;
        if (sbq.size() == 0) check("evt_unexpected", {22'd0, evt_ext, evt_break, evt_code}, 32'hFFFF_FFFF);
        else check("evt", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, sbq.pop_front()});
      end
    end
  end

  task automatic ps2_edge(input logic b, input bit pop_here);
    ps2_data = b;
    repeat (HALF) @(posedge clk); #1;
    ps2_clk = 0;
    if (pop_here) begin
      repeat (3) @(posedge clk); #1 evt_ready = 1;
      @(posedge clk); #1 evt_ready = 0;
      repeat (HALF - 4) @(posedge clk); #1;
    end else begin
      repeat (HALF) @(posedge clk); #1;
    end
    ps2_clk = 1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input logic stop, input bit pop_stop);
    ps2_edge(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_edge(code[i], 0);
    ps2_edge((~^code) ^ bad_par, 0);
    ps2_edge(stop, pop_stop);
    repeat (6) @(posedge clk); #1;
  endtask

  task automatic send_make(input logic [7:0] code);
    sbq.push_back({2'b00, code});
    send_frame(code, 0, 1'b1, 0);
  endtask

  task automatic drain();
    int n;
    evt_ready = 1;
    n = 0;
    while (fifo_level != 0 && n < 40) begin @(posedge clk); #1; n++; end
    check("drain_done", {28'd0, fifo_level}, 32'd0);
    evt_ready = 0;
  endtask

  int e0, v0, p0;

  initial begin
    repeat (3) @(posedge clk); #1;
    check("rst_valid", evt_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_count", key_count, 0);
    check("rst_busy_ovf_err", {busy, overflow, frame_err}, 0);
    rst = 1;
    repeat (3) @(posedge clk); #1;

    // Single make event
    evt_ready = 1;
    v0 = vcycles; p0 = popped;
    send_make(8'h1C);
    check("first_popped", popped - p0, 1);
    check("first_valid_cycles", vcycles - v0, 1);
    check("first_count", key_count, 1);

    // Extended break sequence
    mark++;
    p0 = popped;
    sbq.push_back({2'b11, 8'h75});
    send_frame(8'hE0, 0, 1'b1, 0);
    send_frame(8'hF0, 0, 1'b1, 0);
    send_frame(8'h75, 0, 1'b1, 0);
    check("ext_brk_popped", popped - p0, 1);
    check("ext_brk_peak", peak, 1);
    check("ext_brk_count", key_count, 1);

    // Bad parity, then bad stop
    e0 = err_cycles; p0 = popped;
    send_frame(8'h1C, 1, 1'b1, 0);
    check("parity_err", err_cycles - e0, 1);
    check("parity_no_evt", popped - p0, 0);
    send_make(8'h32);
    check("after_parity_count", key_count, 2);
    e0 = err_cycles; p0 = popped;
    send_frame(8'h1C, 0, 1'b0, 0);
    check("stop_err", err_cycles - e0, 1);
    check("stop_no_evt", popped - p0, 0);
    send_make(8'h32);
    check("after_stop_count", key_count, 3);

    // Truncated frame aborted by timeout
    e0 = err_cycles;
    ps2_edge(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_edge(1'b1, 0);
    check("partial_busy", busy, 1);
    repeat (TMO + 10) @(posedge clk); #1;
    check("timeout_err", err_cycles - e0, 1);
    check("timeout_busy", busy, 0);
    send_make(8'h24);
    check("after_timeout_count", key_count, 4);

    // Fill and overflow
    evt_ready = 0;
    for (int i = 0; i < 8; i++) send_make(8'h10 + 8'(i));
    check("full_level", fifo_level, 8);
    check("full_no_ovf", overflow, 0);
    send_frame(8'h18, 0, 1'b1, 0);
    check("ovf_set", overflow, 1);
    check("ovf_level", fifo_level, 8);
    check("ovf_count", key_count, 12);
    drain();
    check("ovf_sticky", overflow, 1);
    ovf_clr = 1; @(posedge clk); #1 ovf_clr = 0;
    check("ovf_cleared", overflow, 0);

    // Push coinciding with pop on a full FIFO
    for (int i = 0; i < 8; i++) send_make(8'h40 + 8'(i));
    check("full2_level", fifo_level, 8);
    sbq.push_back({2'b00, 8'h48});
    send_frame(8'h48, 0, 1'b1, 1);
    check("pushpop_no_ovf", overflow, 0);
    check("pushpop_level", fifo_level, 8);
    check("pushpop_count", key_count, 21);
    drain();
    check("sb_empty", sbq.size(), 0);

    // Asynchronous reset mid-frame with FIFO content
    send_make(8'h5A);
    check("pre_rst_level", fifo_level, 1);
    ps2_edge(1'b0, 0);
    ps2_edge(1'b1, 0);
    ps2_edge(1'b0, 0);
    check("pre_rst_busy", busy, 1);
    #3 rst = 0;
    #1;
    check("arst_valid_level", {evt_valid, fifo_level}, 0);
    check("arst_count", key_count, 0);
    check("arst_busy_ovf_err", {busy, overflow, frame_err, evt_code}, 0);
    sbq.delete();
    @(posedge clk); #1 rst = 1;
    ps2_data = 1;
    repeat (3) @(posedge clk); #1;
    evt_ready = 1;
    p0 = popped;
    send_make(8'h1C);
    check("post_rst_popped", popped - p0, 1);
    check("post_rst_count", key_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
